// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard and stall generation.
// Optional same-cycle write-through on the read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  output logic            busy1,
  output logic            busy2,
  output logic            stall,
  input  logic            issue_en,
  input  logic [4:0]      issue_rd,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            flush,
  output logic [5:0]      pending_cnt
);

  localparam int unsigned AW    = 5;
  localparam int unsigned NSLOT = 32;

  logic [XLEN-1:0]  w_regs [NSLOT];
  logic [NSLOT-1:0] w_busy;

  // Every 5-bit address owns a slot; slots that are not real storage read as 0/not-busy.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if ((g < NREGS) && !((ZERO_REG != 0) && (g == 0))) begin : g_live
      localparam logic [AW-1:0] IDX = AW'(g);
      logic [XLEN-1:0] r_data;
      logic            r_busy;
      logic            w_wr_hit;
      logic            w_iss_hit;

      assign w_wr_hit  = wr_en && (wr_addr == IDX);
      assign w_iss_hit = issue_en && (issue_rd == IDX);

      // Flush beats issue; a fresh issue beats a coincident writeback clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_data <= '0;
          r_busy <= 1'b0;
        end else begin
          if (w_wr_hit) begin
            r_data <= wr_data;
          end
          if (flush) begin
            r_busy <= 1'b0;
          end else if (w_iss_hit) begin
            r_busy <= 1'b1;
          end else if (w_wr_hit) begin
            r_busy <= 1'b0;
          end
        end
      end

      assign w_regs[g] = r_data;
      assign w_busy[g] = r_busy;
    end else begin : g_dead
      assign w_regs[g] = '0;
      assign w_busy[g] = 1'b0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_wr_valid;

  // Reset forces zeros on the read ports, so write-through is suppressed during it.
  assign w_wr_valid = !rst && wr_en && ({1'b0, wr_addr} < 6'(NREGS))
                      && !((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    rd_data1 = w_regs[rs1_addr];
    busy1    = w_busy[rs1_addr];
    rd_data2 = w_regs[rs2_addr];
    busy2    = w_busy[rs2_addr];
    if (w_wr_valid && (wr_addr == rs1_addr)) begin
      rd_data1 = wr_data;
      busy1    = 1'b0;
    end
    if (w_wr_valid && (wr_addr == rs2_addr)) begin
      rd_data2 = wr_data;
      busy2    = 1'b0;
    end
  end
`else
  assign rd_data1 = w_regs[rs1_addr];
  assign busy1    = w_busy[rs1_addr];
  assign rd_data2 = w_regs[rs2_addr];
  assign busy2    = w_busy[rs2_addr];
`endif

  assign stall = (rs1_used && busy1) || (rs2_used && busy2);

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < NSLOT; i++) begin
      pending_cnt = pending_cnt + 6'(w_busy[i]);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: two register-file configurations against an array-based model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wr_addr;
  logic        rs1_used, rs2_used, issue_en, wr_en, flush;
  logic [31:0] wr_data;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_b1, a_b2, a_st, b_b1, b_b2, b_st;
  logic [5:0]  a_cnt, b_cnt;

  regfile_scoreboard dut_a (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_data1(a_rd1), .rd_data2(a_rd2),
    .busy1(a_b1), .busy2(a_b2), .stall(a_st), .issue_en(issue_en), .issue_rd(issue_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .pending_cnt(a_cnt)
  );

  regfile_scoreboard #(.NREGS(16), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_data1(b_rd1), .rd_data2(b_rd2),
    .busy1(b_b1), .busy2(b_b2), .stall(b_st), .issue_en(issue_en), .issue_rd(issue_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .pending_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model: index 0 = 32 regs with x0 hardwired, index 1 = 16 regs with ordinary x0.
  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];

  function automatic int nr(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit valid(int k, logic [4:0] a);
    return (int'(a) < nr(k)) && !((k == 0) && (a == 5'd0));
  endfunction

  function automatic bit byp_hit(int k, logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    return !rst && wr_en && valid(k, wr_addr) && (wr_addr == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(int k, logic [4:0] a);
    if (!valid(k, a)) return 32'h0;
    if (byp_hit(k, a)) return wr_data;
    return m_reg[k][a];
  endfunction

  function automatic logic exp_busy(int k, logic [4:0] a);
    if (!valid(k, a) || byp_hit(k, a)) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic int exp_cnt(int k);
    int s = 0;
    for (int a = 0; a < 32; a++) s += int'(m_busy[k][a]);
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) begin
        m_reg[k][a]  = 32'h0;
        m_busy[k][a] = 1'b0;
      end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (wr_en && valid(k, wr_addr)) begin
        m_reg[k][wr_addr]  = wr_data;
        m_busy[k][wr_addr] = 1'b0;
      end
      if (flush) begin
        for (int a = 0; a < 32; a++) m_busy[k][a] = 1'b0;
      end else if (issue_en && valid(k, issue_rd)) begin
        m_busy[k][issue_rd] = 1'b1;
      end
    end
  endtask

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(int k, logic [31:0] d1, logic [31:0] d2, logic b1, logic b2,
                            logic st, logic [5:0] cnt);
    logic eb1, eb2;
    string t;
    t   = (k == 0) ? "a" : "b";
    eb1 = exp_busy(k, rs1_addr);
    eb2 = exp_busy(k, rs2_addr);
    cmp({t, "_rd_data1"}, 64'(d1), 64'(exp_data(k, rs1_addr)));
    cmp({t, "_rd_data2"}, 64'(d2), 64'(exp_data(k, rs2_addr)));
    cmp({t, "_busy1"}, 64'(b1), 64'(eb1));
    cmp({t, "_busy2"}, 64'(b2), 64'(eb2));
    cmp({t, "_stall"}, 64'(st), 64'((rs1_used & eb1) | (rs2_used & eb2)));
    cmp({t, "_pending_cnt"}, 64'(cnt), 64'(exp_cnt(k)));
  endtask

  // Continuous compare of both instances against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check_inst(0, a_rd1, a_rd2, a_b1, a_b2, a_st, a_cnt);
      check_inst(1, b_rd1, b_rd2, b_b1, b_b2, b_st, b_cnt);
    end
  end

  task automatic idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    issue_en = 1'b0; issue_rd = 5'd0; wr_en = 1'b0; wr_addr = 5'd0;
    wr_data = 32'h0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    model_reset();
    idle();
    chk_on = 1'b1;
    step();
    step();
    cmp("reset_rd_data1", 64'(a_rd1), 64'h0);
    cmp("reset_pending_cnt", 64'(a_cnt), 64'h0);
    rst = 1'b0;

    // Reset in the middle of operation, including a write held across the reset edge.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    issue_en = 1'b1; issue_rd = 5'd7;
    step();
    idle(); rs1_addr = 5'd5;
    #1;
    cmp("mid_pre_rd_data1", 64'(a_rd1), 64'hDEADBEEF);
    cmp("mid_pre_pending_cnt", 64'(a_cnt), 64'd1);
    rst = 1'b1;
    model_reset();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
    #1;
    cmp("mid_rst_rd_data1", 64'(a_rd1), 64'h0);
    cmp("mid_rst_pending_cnt", 64'(a_cnt), 64'h0);
    step();
    rst = 1'b0;
    idle(); rs1_addr = 5'd5;
    step();
    cmp("post_rst_rd_data1", 64'(a_rd1), 64'h0);

    // Scoreboard stall on a pending source.
    issue_en = 1'b1; issue_rd = 5'd3;
    step();
    idle(); rs1_addr = 5'd3; rs1_used = 1'b1;
    #1;
    cmp("stall_busy1", 64'(a_b1), 64'd1);
    cmp("stall_raised", 64'(a_st), 64'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12;
    #1;
`ifdef REGFILE_BYPASS_EN
    cmp("stall_same_cycle", 64'(a_st), 64'd0);
`else
    cmp("stall_same_cycle", 64'(a_st), 64'd1);
`endif
    step();
    wr_en = 1'b0;
    #1;
    cmp("stall_cleared", 64'(a_st), 64'd0);
    cmp("stall_rd_data1", 64'(a_rd1), 64'h12);

    // Register 0: hardwired in instance a, ordinary in instance b.
    idle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    issue_en = 1'b1; issue_rd = 5'd0;
    step();
    idle();
    #1;
    cmp("x0_a_rd_data1", 64'(a_rd1), 64'h0);
    cmp("x0_a_busy1", 64'(a_b1), 64'd0);
    cmp("x0_a_pending_cnt", 64'(a_cnt), 64'd0);
    cmp("x0_b_rd_data1", 64'(b_rd1), 64'hFFFFFFFF);
    cmp("x0_b_busy1", 64'(b_b1), 64'd1);

    // Simultaneous issue and write, then flush against a coincident issue.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A50009;
    issue_en = 1'b1; issue_rd = 5'd9;
    step();
    idle(); rs1_addr = 5'd9;
    #1;
    cmp("iw_rd_data1", 64'(a_rd1), 64'hA5A50009);
    cmp("iw_busy1", 64'(a_b1), 64'd1);
    flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd4; rs2_addr = 5'd4;
    step();
    idle(); rs2_addr = 5'd4;
    #1;
    cmp("flush_a_pending_cnt", 64'(a_cnt), 64'd0);
    cmp("flush_b_pending_cnt", 64'(b_cnt), 64'd0);
    cmp("flush_busy2", 64'(a_b2), 64'd0);

    // Write-through visibility on read port 2.
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h11;
    step();
    wr_data = 32'h55; rs2_addr = 5'd12;
    #1;
`ifdef REGFILE_BYPASS_EN
    cmp("byp_rd_data2", 64'(a_rd2), 64'h55);
`else
    cmp("byp_rd_data2", 64'(a_rd2), 64'h11);
`endif
    step();
    idle(); rs2_addr = 5'd12;
    #1;
    cmp("byp_rd_data2_after", 64'(a_rd2), 64'h55);

    // Address beyond NREGS on the 16-register instance.
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h20202020;
    issue_en = 1'b1; issue_rd = 5'd20;
    step();
    idle(); rs1_addr = 5'd20;
    #1;
    cmp("oor_b_rd_data1", 64'(b_rd1), 64'h0);
    cmp("oor_b_busy1", 64'(b_b1), 64'd0);
    cmp("oor_b_pending_cnt", 64'(b_cnt), 64'd0);
    cmp("oor_a_rd_data1", 64'(a_rd1), 64'h20202020);
    cmp("oor_a_busy1", 64'(a_b1), 64'd1);

    // Randomized traffic with occasional asynchronous reset.
    for (int c = 0; c < 3000; c++) begin
      rst      = 1'b0;
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      issue_en = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 31));
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) wr_addr = rs1_addr;
      if ($urandom_range(0, 7) == 0) wr_addr = rs2_addr;
      wr_data  = $urandom;
      flush    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1;
        rst = 1'b1;
        model_reset();
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised next-generation integer register file for the pipelined FemtoRV32 core: NREGS x XLEN storage, two asynchronous read ports, one synchronous write port.
- Adds a per-register busy scoreboard. Decode marks a destination pending at issue; writeback clears it. The block raises a stall when a consumed source is still pending.
- Sits between decode (read/issue side) and writeback (write side). Replaces the fixed 32x32 negedge-write register file.

Parameters:
- XLEN, 32, data width of each register in bits.
- NREGS, 32, number of architectural registers (2..32); address ports are always 5 bits.
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes and issues to it ignored); 0 = register 0 is ordinary storage.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rs1_addr  input  5  read port 1 address.
- rs2_addr  input  5  read port 2 address.
- rs1_used  input  1  decode consumes rs1 this cycle.
- rs2_used  input  1  decode consumes rs2 this cycle.
- rd_data1  output  XLEN  read port 1 data.
- rd_data2  output  XLEN  read port 2 data.
- busy1  output  1  rs1 register has a pending write.
- busy2  output  1  rs2 register has a pending write.
- stall  output  1  (rs1_used & busy1) | (rs2_used & busy2).
- issue_en  input  1  decode issues an instruction that writes issue_rd.
- issue_rd  input  5  destination register being issued.
- wr_en  input  1  writeback valid.
- wr_addr  input  5  writeback destination.
- wr_data  input  XLEN  writeback data.
- flush  input  1  pipeline flush; clears all busy bits.
- pending_cnt  output  6  number of busy bits currently set (0..NREGS).

Behaviour:
- Reset (rst=1, any time, mid-operation included): all registers 0, all busy bits 0, immediately and asynchronously. Outputs then read: rd_data1/2=0, busy1/2=0, stall=0, pending_cnt=0. A write or issue in the same cycle as reset is discarded.
- Valid address: addr < NREGS, and not (ZERO_REG=1 and addr=0).
- Write: at posedge, if wr_en and wr_addr valid, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. Invalid wr_addr: no effect.
- Issue: at posedge, if issue_en and issue_rd valid and not flush, busy[issue_rd] <= 1.
- Issue and write to the same register in the same cycle: data written, busy ends 1 (the new producer wins).
- Flush: at posedge, all busy bits <= 0. Flush beats issue in the same cycle. A coincident write still updates storage.
- Read: combinational. rd_dataN = reg[rsN_addr]. Address >= NREGS returns 0. With ZERO_REG=1, address 0 returns 0.
- busyN = busy[rsN_addr], or 0 for an invalid address.
- stall is combinational from busy1/busy2/rs*_used. No latency.
- pending_cnt: combinational popcount of the busy vector.
- No write-after-write tracking: a second issue to an already-busy register leaves it busy. The first matching writeback clears it.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-through. If wr_en, wr_addr valid and wr_addr==rsN_addr, then rd_dataN=wr_data and busyN=0 combinationally in that cycle, so stall drops one cycle earlier.
- Undefined: reads see only stored state. Written data and the busy clear become visible the cycle after the write edge.

Test Plan:
- Reset mid-run: write reg5=0xDEADBEEF, issue rd=7, assert rst between edges -> rd_data1 (rs1=5) = 0 and pending_cnt=0 immediately; after release reg5 reads 0.
- Scoreboard stall: issue rd=3; next cycle rs1=3, rs1_used=1 -> busy1=1, stall=1; wr_en wr_addr=3 wr_data=0x12 -> stall=0 after edge (same cycle with REGFILE_BYPASS_EN) and rd_data1=0x12.
- Zero register, ZERO_REG=1: write 0xFFFFFFFF to x0 and issue rd=0 -> rd_data1=0, busy1=0, pending_cnt unchanged.
- Simultaneous issue+write to rd=9 -> reg9=wr_data, busy1(rs1=9)=1 next cycle; flush with issue rd=4 -> pending_cnt=0, busy for 4 = 0.
- Bypass check, macro on vs off: write 0x55 to rd=12 with rs2=12 -> rd_data2=0x55 combinationally (on) vs old value until next edge (off).
- NREGS=16: write/issue/read with address 20 -> no state change, rd_data=0, busy=0.
